// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg -- shared constants and types for the 8-way round-robin arbiter.
//   N_REQ       : number of requesters
//   ID_W        : width of a requester index
//   HOLD_W      : width of the grant hold counter
//   arb_state_t : arbiter FSM state (IDLE=0, GRANT=1)
// ---------------------------------------------------------------------------
package arb_pkg;
    localparam int unsigned N_REQ  = 8;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage : arb_pkg

// File: rtl/prio_enc83.sv
// ---------------------------------------------------------------------------
// prio_enc83 -- combinational 8-to-3 priority encoder, lowest set bit wins.
//   i_vec   : input vector to search
//   o_idx   : index of the lowest set bit (0 when none set)
//   o_valid : high when any bit of i_vec is set
// ---------------------------------------------------------------------------
module prio_enc83
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_valid
);

    logic w_found;

    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (i_vec[i] && !w_found) begin
                o_idx   = ID_W'(i);
                w_found = 1'b1;
            end
        end
        o_valid = w_found;
    end

endmodule : prio_enc83

// File: rtl/rr_arb8.sv
// ---------------------------------------------------------------------------
// rr_arb8 -- 8-requester round-robin arbiter with hold-time limit.
//   MAX_HOLD  : maximum number of cycles a single grant may be held (2..255)
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : request vector, bit i = requester i
//   done      : owner releases the grant (only looked at while granting)
//   gnt       : registered one-hot grant vector, zero when idle
//   gnt_id    : registered binary index of the owner, zero when idle
//   gnt_valid : registered, high exactly when gnt is non-zero
//   timeout   : one-cycle pulse when a grant is forcibly released
// ---------------------------------------------------------------------------
module rr_arb8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t        r_state,     w_nxt_state;
    logic [ID_W-1:0]   r_ptr,       w_nxt_ptr;
    logic [HOLD_W-1:0] r_hold,      w_nxt_hold;
    logic [N_REQ-1:0]  r_gnt,       w_nxt_gnt;
    logic [ID_W-1:0]   r_gnt_id,    w_nxt_gnt_id;
    logic              r_gnt_valid, w_nxt_gnt_valid;
    logic              r_timeout,   w_nxt_timeout;

    logic [N_REQ-1:0]  w_rot;
    logic [ID_W-1:0]   w_idx;
    logic              w_any;
    logic [ID_W-1:0]   w_winner;
    logic              w_owner_req;
    logic              w_at_limit;

    // Rotate right by ptr so the search starts at ptr; index math wraps in ID_W bits.
    always_comb begin
        w_rot = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            w_rot[j] = req[ID_W'(j) + r_ptr];
        end
    end

    prio_enc83 u_enc (
        .i_vec   (w_rot),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign w_winner    = w_idx + r_ptr;
    assign w_owner_req = req[r_gnt_id];
    assign w_at_limit  = (r_hold == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_hold      <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_ptr       <= w_nxt_ptr;
            r_hold      <= w_nxt_hold;
            r_gnt       <= w_nxt_gnt;
            r_gnt_id    <= w_nxt_gnt_id;
            r_gnt_valid <= w_nxt_gnt_valid;
            r_timeout   <= w_nxt_timeout;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_ptr       = r_ptr;
        w_nxt_hold      = r_hold;
        w_nxt_gnt       = r_gnt;
        w_nxt_gnt_id    = r_gnt_id;
        w_nxt_gnt_valid = r_gnt_valid;
        w_nxt_timeout   = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_nxt_gnt       = '0;
                w_nxt_gnt_id    = '0;
                w_nxt_gnt_valid = 1'b0;
                if (w_any) begin
                    w_nxt_state            = GRANT;
                    w_nxt_hold             = '0;
                    w_nxt_gnt[w_winner]    = 1'b1;
                    w_nxt_gnt_id           = w_winner;
                    w_nxt_gnt_valid        = 1'b1;
                end
            end
            GRANT: begin
                if (done || !w_owner_req || w_at_limit) begin
                    w_nxt_state     = IDLE;
                    w_nxt_ptr       = r_gnt_id + ID_W'(1);
                    w_nxt_hold      = '0;
                    w_nxt_gnt       = '0;
                    w_nxt_gnt_id    = '0;
                    w_nxt_gnt_valid = 1'b0;
                    // Only a pure hold-limit release counts as a timeout.
                    w_nxt_timeout   = w_at_limit && !done && w_owner_req;
                end else begin
                    w_nxt_hold = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule : rr_arb8

// File: tb/tb_rr_arb8.sv
module tb_rr_arb8;

    localparam int MAXH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    rr_arb8 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_owner = -1;   // -1 = nobody holds the grant
    int m_ptr   = 0;
    int m_held  = 0;    // cycles the current grant has been visible, minus one
    bit m_to    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
                end
                m_held = 0;
            end else begin
                bit lim;
                lim = (m_held + 1 >= MAXH);
                if (done || !req[m_owner] || lim) begin
                    m_to    = lim && !done && req[m_owner];
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = -1;
                end else begin
                    m_held++;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_gnt",   int'(gnt),       (m_owner < 0) ? 0 : (1 << m_owner));
        check("model_id",    int'(gnt_id),    (m_owner < 0) ? 0 : m_owner);
        check("model_valid", int'(gnt_valid), (m_owner < 0) ? 0 : 1);
        check("model_to",    int'(timeout),   int'(m_to));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req = '0; done = 1'b0;
        tick; tick;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_valid;
        rst_n = 1'b0; req = '0; done = 1'b0;
        #1;
        check("rst_gnt",   int'(gnt), 0);
        check("rst_valid", int'(gnt_valid), 0);
        check("rst_to",    int'(timeout), 0);
        do_reset;

        // Single requester, done on third grant cycle.
        req = 8'h01;
        tick;
        check("t27_gnt", int'(gnt), 8'h01);
        check("t27_id",  int'(gnt_id), 0);
        tick; tick;
        done = 1'b1;
        tick;
        done = 1'b0; req = '0;
        check("t27_rel_valid", int'(gnt_valid), 0);
        check("t27_ptr", m_ptr, 1);
        tick;

        // All requesting, done each grant: 0..7,0 with an idle cycle between.
        do_reset;
        req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            tick;
            check("t28_id",    int'(gnt_id), n % 8);
            check("t28_valid", int'(gnt_valid), 1);
            done = 1'b1;
            tick;
            done = 1'b0;
            check("t28_idle", int'(gnt_valid), 0);
        end
        req = '0;
        tick;

        // Wrap-around search from ptr=6.
        do_reset;
        req = 8'h20;
        tick;
        check("t29_id5", int'(gnt_id), 5);
        done = 1'b1;
        tick;
        done = 1'b0; req = 8'h03;
        check("t29_ptr6", m_ptr, 6);
        tick;
        check("t29_id", int'(gnt_id), 0);
        done = 1'b1;
        tick;
        done = 1'b0; req = '0;
        check("t29_ptr1", m_ptr, 1);
        tick;

        // Hold limit: 16 grant cycles then one timeout pulse.
        do_reset;
        req = 8'h10;
        tick;
        n_valid = 0;
        for (int i = 0; i < 40 && gnt_valid; i++) begin
            n_valid++;
            check("t30_noto", int'(timeout), 0);
            tick;
        end
        req = '0;
        check("t30_cycles", n_valid, 16);
        check("t30_to",     int'(timeout), 1);
        check("t30_ptr",    m_ptr, 5);
        tick;
        check("t30_to_off", int'(timeout), 0);

        // Owner drops its request: release without timeout.
        do_reset;
        req = 8'h04;
        tick;
        check("t31_id", int'(gnt_id), 2);
        tick;
        req = '0;
        tick;
        check("t31_valid", int'(gnt_valid), 0);
        check("t31_to",    int'(timeout), 0);
        tick;
        check("t31_to2",   int'(timeout), 0);

        // Asynchronous reset mid-grant.
        do_reset;
        req = 8'h08;
        tick;
        check("t32_id3", int'(gnt_id), 3);
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("t32_gnt",   int'(gnt), 0);
        check("t32_valid", int'(gnt_valid), 0);
        check("t32_to",    int'(timeout), 0);
        req = 8'h80;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("t32_id7", int'(gnt_id), 7);
        check("t32_gnt7", int'(gnt), 8'h80);
        req = '0;
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rr_arb8

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, maximum cycles one grant may be held (range 2..255).
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 8, request per requester; bit i = requester i.
REQ-005 SHALL have port done, input, 1, owner releases the grant; sampled only in GRANT.
REQ-006 SHALL have port gnt, output, 8, one-hot grant vector; all-zero when no grant.
REQ-007 SHALL have port gnt_id, output, 3, binary index of the granted requester; 0 when no grant.
REQ-008 SHALL have port gnt_valid, output, 1, high exactly when gnt is non-zero.
REQ-009 SHALL have port timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-010 SHALL implement states IDLE and GRANT; all outputs registered.
REQ-011 IDLE: if req != 0 at an edge, SHALL enter GRANT at that edge with the winner's gnt, gnt_id and gnt_valid=1 visible in the next cycle (1-cycle latency).
REQ-012 Winner SHALL be the first set req bit found searching upward from pointer ptr, wrapping 7 -> 0.
REQ-013 IDLE with req == 0 SHALL stay IDLE with all outputs 0.
REQ-014 GRANT SHALL hold gnt/gnt_id constant regardless of other req changes.
REQ-015 GRANT SHALL release at an edge where done=1, or req[owner]=0, or hold count = MAX_HOLD-1, going to IDLE with gnt=0, gnt_id=0, gnt_valid=0.
REQ-016 Hold counter SHALL be 8 bits, SHALL clear on entry to GRANT and SHALL increment each GRANT cycle.
REQ-017 timeout SHALL pulse for one cycle only when the release is caused by the hold limit alone (done=0 and req[owner]=1).
REQ-018 On any release, ptr SHALL become (owner+1) mod 8 (3-bit wrap, 7 -> 0).
REQ-019 After a release, at least one IDLE cycle (gnt=0) SHALL occur before the next grant.
REQ-020 done in IDLE SHALL be ignored.
REQ-021 gnt SHALL never have more than one bit set; gnt_id SHALL equal the index of that bit.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, ptr=0, hold count=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
REQ-023 Reset asserted mid-GRANT SHALL drop the grant asynchronously, with no timeout pulse.
REQ-024 After rst_n deassertion, the first grant SHALL follow REQ-011 using ptr=0.

Structure
REQ-025 Shared package arb_pkg SHALL hold N_REQ=8, ID_W=3, the state encoding (IDLE=0, GRANT=1) and HOLD_W=8.
REQ-026 Sub-module prio_enc83 SHALL be instantiated once: combinational 8-to-3 priority encoder (lowest set bit wins) with a valid output. It operates on req rotated right by ptr; the winner is (index + ptr) mod 8.

Verification
REQ-027 Reset, then req=8'b0000_0001 held, done pulsed on the 3rd grant cycle -> gnt=8'h01, gnt_id=0 one cycle after request; release after done; ptr=1.
REQ-028 req=8'hFF constant, done pulsed each grant -> gnt_id sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-029 ptr=6, req=8'b0000_0011 -> gnt_id=0 (wrap search), then ptr=1 after release.
REQ-030 req=8'h10 held, done never asserted, MAX_HOLD=16 -> gnt held 16 cycles, timeout=1 for exactly one cycle at release, ptr=5.
REQ-031 Owner req drops with done=0 -> release next edge, timeout stays 0.
REQ-032 rst_n pulled low mid-GRANT -> gnt=0 and gnt_valid=0 immediately; after release, req=8'h80 -> gnt_id=7 with ptr=0 search.
